// File: rtl/abs_frame_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// abs_frame_pkg
// Shared types and constants for the absolute-value frame accumulator.
//   state_e     : frame FSM state (ACCUM collects samples, HOLD presents a sum)
//   DEFAULT_DW  : magnitude width produced by the upstream abs stage
//   acc_width() : frame-sum width wide enough that FRAME_LEN full-scale
//                 magnitudes can never overflow
// -----------------------------------------------------------------------------
package abs_frame_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DEFAULT_DW = 8;

    function automatic int acc_width(input int dw, input int frame_len);
        return dw + $clog2(frame_len);
    endfunction

endpackage

// File: rtl/abs_frame_accumulator_if.sv
// -----------------------------------------------------------------------------
// abs_frame_accumulator_if
// Sample-in / frame-sum-out bundle for abs_frame_accumulator.
//   in_mag, in_valid, in_ready     : magnitude stream from the abs stage
//   frame_clr                      : synchronous abort of the current frame
//   out_sum, out_valid, out_ready  : frame-sum handshake toward level detect
//   out_peak                       : frame peak, only when ABS_FRAME_PEAK_EN
// Modports: master drives samples and consumes sums, slave is the accumulator.
// ACC_W is derived here so the bus and the block always agree on sum width.
// -----------------------------------------------------------------------------
interface abs_frame_accumulator_if #(
    parameter int DW        = abs_frame_pkg::DEFAULT_DW,
    parameter int FRAME_LEN = 16
);
    localparam int ACC_W = abs_frame_pkg::acc_width(DW, FRAME_LEN);

    logic [DW-1:0]    in_mag;
    logic             in_valid;
    logic             in_ready;
    logic             frame_clr;
    logic [ACC_W-1:0] out_sum;
    logic             out_valid;
    logic             out_ready;
`ifdef ABS_FRAME_PEAK_EN
    logic [DW-1:0]    out_peak;

    modport master (
        output in_mag, in_valid, frame_clr, out_ready,
        input  in_ready, out_sum, out_valid, out_peak
    );

    modport slave (
        input  in_mag, in_valid, frame_clr, out_ready,
        output in_ready, out_sum, out_valid, out_peak
    );
`else
    modport master (
        output in_mag, in_valid, frame_clr, out_ready,
        input  in_ready, out_sum, out_valid
    );

    modport slave (
        input  in_mag, in_valid, frame_clr, out_ready,
        output in_ready, out_sum, out_valid
    );
`endif

endinterface

// File: rtl/abs_frame_accumulator_ctr.sv
// -----------------------------------------------------------------------------
// abs_frame_ctr
// Counts accepted samples within a frame and flags the final one.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   inc   : a sample was accepted this cycle
//   clr   : abort the frame, count restarts at zero (wins over inc)
//   last  : the next accepted sample completes the frame (cnt == FRAME_LEN-1)
// -----------------------------------------------------------------------------
module abs_frame_ctr #(
    parameter int FRAME_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic last
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_VAL = CW'(FRAME_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last = (cnt_q == LAST_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            // Explicit wrap: FRAME_LEN need not be a power of two.
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/abs_frame_accumulator.sv
// -----------------------------------------------------------------------------
// abs_frame_accumulator
// Sums FRAME_LEN unsigned magnitudes from the abs stage and holds the frame
// sum on a valid/ready output until the consumer takes it.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : abs_frame_accumulator_if.slave (samples in, frame sum out)
// Optional: define ABS_FRAME_PEAK_EN to also report the frame maximum on
// bus.out_peak, registered alongside out_sum.
// Timing: last sample accepted at edge k -> out_valid after edge k; in_ready
// returns the edge after the output handshake, leaving one bubble cycle.
// -----------------------------------------------------------------------------
module abs_frame_accumulator
    import abs_frame_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int FRAME_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    abs_frame_accumulator_if.slave bus
);
    localparam int ACC_W = acc_width(DW, FRAME_LEN);

    state_e           state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [ACC_W-1:0] out_sum_q,   out_sum_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;
`ifdef ABS_FRAME_PEAK_EN
    logic [DW-1:0]    peak_run_q,  peak_run_d;
    logic [DW-1:0]    out_peak_q,  out_peak_d;
`endif

    logic             accept;
    logic             last;
    logic [ACC_W-1:0] mag_ext;

    // in_ready_q is only ever high in ACCUM, so accept implies ACCUM.
    assign accept  = bus.in_valid & in_ready_q;
    assign mag_ext = ACC_W'(bus.in_mag);

    abs_frame_ctr #(
        .FRAME_LEN (FRAME_LEN)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept & ~bus.frame_clr),
        .clr   (bus.frame_clr),
        .last  (last)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef ABS_FRAME_PEAK_EN
        peak_run_d  = peak_run_q;
        out_peak_d  = out_peak_q;
`endif
        if (bus.frame_clr) begin
            // Abort beats accept and out_ready; a sample offered this cycle
            // is swallowed. out_sum keeps its last completed value.
            state_d     = ACCUM;
            acc_d       = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
`ifdef ABS_FRAME_PEAK_EN
            peak_run_d  = '0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            out_sum_d   = acc_q + mag_ext;
                            acc_d       = '0;
                            state_d     = HOLD;
                            out_valid_d = 1'b1;
                            in_ready_d  = 1'b0;
`ifdef ABS_FRAME_PEAK_EN
                            out_peak_d  = (bus.in_mag > peak_run_q) ? bus.in_mag : peak_run_q;
                            peak_run_d  = '0;
`endif
                        end else begin
                            acc_d = acc_q + mag_ext;
`ifdef ABS_FRAME_PEAK_EN
                            // Strict compare: equal values leave the peak alone.
                            if (bus.in_mag > peak_run_q) begin
                                peak_run_d = bus.in_mag;
                            end
`endif
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d     = ACCUM;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
                default: begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ABS_FRAME_PEAK_EN
            peak_run_q  <= '0;
            out_peak_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef ABS_FRAME_PEAK_EN
            peak_run_q  <= peak_run_d;
            out_peak_q  <= out_peak_d;
`endif
        end
    end

    assign bus.out_sum   = out_sum_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
`ifdef ABS_FRAME_PEAK_EN
    assign bus.out_peak  = out_peak_q;
`endif

endmodule

// File: tb/tb_abs_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_abs_frame_accumulator
// Two instances: u_a with FRAME_LEN=4 (DW=8, ACC_W=10) and u_b with
// FRAME_LEN=16 (ACC_W=12). Expected frame results are queued when a frame is
// driven and compared by a monitor when the output handshake happens.
// Peak checks are compiled in with ABS_FRAME_PEAK_EN.
// -----------------------------------------------------------------------------
module tb_abs_frame_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    abs_frame_accumulator_if #(.DW(8), .FRAME_LEN(4))  a_if ();
    abs_frame_accumulator_if #(.DW(8), .FRAME_LEN(16)) b_if ();

    abs_frame_accumulator #(.DW(8), .FRAME_LEN(4)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    abs_frame_accumulator #(.DW(8), .FRAME_LEN(16)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    typedef struct {
        int sum;
        int peak;
    } exp_t;

    typedef struct {
        logic [3:0][7:0] m;
        int              exp_sum;
        int              exp_peak;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input int m0, input int m1, input int m2, input int m3,
                                input int s, input int p);
        vec_t v;
        v.m[0] = 8'(m0);
        v.m[1] = 8'(m1);
        v.m[2] = 8'(m2);
        v.m[3] = 8'(m3);
        v.exp_sum  = s;
        v.exp_peak = p;
        return v;
    endfunction

    function automatic exp_t mke(input int s, input int p);
        exp_t e;
        e.sum  = s;
        e.peak = p;
        return e;
    endfunction

    // Offer one sample and hold it until it is accepted (bounded wait).
    task automatic push_a(input int m);
        int guard;
        guard = 0;
        a_if.in_mag   = 8'(m);
        a_if.in_valid = 1'b1;
        while (a_if.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL a_in_ready_timeout: in_ready stuck at %0b, expected 1", a_if.in_ready);
        end
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
    endtask

    task automatic push_b(input int m);
        int guard;
        guard = 0;
        b_if.in_mag   = 8'(m);
        b_if.in_valid = 1'b1;
        while (b_if.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL b_in_ready_timeout: in_ready stuck at %0b, expected 1", b_if.in_ready);
        end
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compare on each completed output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_spurious_output: got out_sum %0d, expected no output", a_if.out_sum);
            end else begin
                e = qa.pop_front();
                chk("a_out_sum", int'(a_if.out_sum), e.sum);
                chk("a_in_ready_in_hold", int'(a_if.in_ready), 0);
`ifdef ABS_FRAME_PEAK_EN
                chk("a_out_peak", int'(a_if.out_peak), e.peak);
`endif
            end
        end
        if (rst_n === 1'b1 && b_if.out_valid === 1'b1 && b_if.out_ready === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_spurious_output: got out_sum %0d, expected no output", b_if.out_sum);
            end else begin
                e = qb.pop_front();
                chk("b_out_sum", int'(b_if.out_sum), e.sum);
`ifdef ABS_FRAME_PEAK_EN
                chk("b_out_peak", int'(b_if.out_peak), e.peak);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[4];

    initial begin
        vecs[0] = mk(5, 128, 17, 128, 278, 128);
        vecs[1] = mk(0, 0, 0, 1, 1, 1);
        vecs[2] = mk(255, 0, 255, 1, 511, 255);
        vecs[3] = mk(3, 9, 9, 2, 23, 9);

        rst_n          = 1'b0;
        a_if.in_mag    = '0;
        a_if.in_valid  = 1'b0;
        a_if.frame_clr = 1'b0;
        a_if.out_ready = 1'b1;
        b_if.in_mag    = '0;
        b_if.in_valid  = 1'b0;
        b_if.frame_clr = 1'b0;
        b_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_out_valid", int'(a_if.out_valid), 0);
        chk("rst_a_in_ready", int'(a_if.in_ready), 1);
        chk("rst_a_out_sum", int'(a_if.out_sum), 0);
        chk("rst_b_out_valid", int'(b_if.out_valid), 0);
`ifdef ABS_FRAME_PEAK_EN
        chk("rst_a_out_peak", int'(a_if.out_peak), 0);
`endif
        rst_n = 1'b1;

        // Basic frame: 10,20,30,40 -> 100, valid exactly one cycle.
        qa.push_back(mke(100, 40));
        push_a(10); push_a(20); push_a(30); push_a(40);
        chk("basic_out_valid_set", int'(a_if.out_valid), 1);
        chk("basic_in_ready_low", int'(a_if.in_ready), 0);
        @(posedge clk); #1;
        chk("basic_out_valid_clear", int'(a_if.out_valid), 0);
        chk("basic_in_ready_back", int'(a_if.in_ready), 1);
        chk("basic_sum_kept", int'(a_if.out_sum), 100);

        // Table-driven frames, back to back.
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mke(vecs[i].exp_sum, vecs[i].exp_peak));
            for (int j = 0; j < 4; j++) push_a(int'(vecs[i].m[j]));
        end
        @(posedge clk); #1;

        // FRAME_LEN=16 full-scale checks.
        qb.push_back(mke(2048, 128));
        for (int i = 0; i < 16; i++) push_b(128);
        qb.push_back(mke(4080, 255));
        for (int i = 0; i < 16; i++) push_b(255);
        @(posedge clk); #1;

        // Backpressure: hold for 5 cycles, offered sample must not be taken.
        a_if.out_ready = 1'b0;
        qa.push_back(mke(100, 40));
        push_a(10); push_a(20); push_a(30); push_a(40);
        a_if.in_mag   = 8'd99;
        a_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", int'(a_if.out_valid), 1);
            chk("hold_out_sum", int'(a_if.out_sum), 100);
            chk("hold_in_ready", int'(a_if.in_ready), 0);
`ifdef ABS_FRAME_PEAK_EN
            chk("hold_out_peak", int'(a_if.out_peak), 40);
`endif
        end
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", int'(a_if.out_valid), 0);
        qa.push_back(mke(10, 4));
        push_a(1); push_a(2); push_a(3); push_a(4);
        @(posedge clk); #1;

        // frame_clr mid-frame with a sample offered in the same cycle.
        push_a(7); push_a(7);
        a_if.frame_clr = 1'b1;
        a_if.in_mag    = 8'd9;
        a_if.in_valid  = 1'b1;
        @(posedge clk); #1;
        a_if.frame_clr = 1'b0;
        a_if.in_valid  = 1'b0;
        chk("clr_in_ready", int'(a_if.in_ready), 1);
        chk("clr_out_valid", int'(a_if.out_valid), 0);
        qa.push_back(mke(10, 4));
        push_a(1); push_a(2); push_a(3); push_a(4);
        @(posedge clk); #1;

        // frame_clr discards a pending result in HOLD.
        a_if.out_ready = 1'b0;
        push_a(5); push_a(5); push_a(5); push_a(5);
        chk("clr_hold_pending", int'(a_if.out_valid), 1);
        a_if.frame_clr = 1'b1;
        @(posedge clk); #1;
        a_if.frame_clr = 1'b0;
        chk("clr_hold_out_valid", int'(a_if.out_valid), 0);
        chk("clr_hold_in_ready", int'(a_if.in_ready), 1);
        chk("clr_hold_sum_kept", int'(a_if.out_sum), 20);
        a_if.out_ready = 1'b1;
        qa.push_back(mke(15, 6));
        push_a(6); push_a(6); push_a(2); push_a(1);
        @(posedge clk); #1;

        // Reset while holding a result; no edge means no effect.
        a_if.out_ready = 1'b0;
        push_a(1); push_a(1); push_a(1); push_a(1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("async_rst_out_valid", int'(a_if.out_valid), 1);
        chk("async_rst_out_sum", int'(a_if.out_sum), 4);
        @(posedge clk); #1;
        chk("sync_rst_out_valid", int'(a_if.out_valid), 0);
        chk("sync_rst_out_sum", int'(a_if.out_sum), 0);
        chk("sync_rst_in_ready", int'(a_if.in_ready), 1);
        rst_n          = 1'b1;
        a_if.out_ready = 1'b1;
        qa.push_back(mke(26, 11));
        push_a(11); push_a(5); push_a(0); push_a(10);

        repeat (4) @(posedge clk);
        #1;
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
